// File: rtl/awg_pkg.sv
// Shared types and constants for the AWG DAC serialiser.
package awg_pkg;

  localparam int         DAC_FRAME_BITS  = 16;
  localparam int         DAC_SAMPLE_BITS = 10;
  localparam logic [3:0] DAC_CMD_NIBBLE  = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    CSHI,
    LDAC
  } dac_state_t;

  // Channel A, unbuffered, gain 1x, active; two trailing don't-care bits.
  function automatic logic [DAC_FRAME_BITS-1:0] dac_frame(
    input logic [DAC_SAMPLE_BITS-1:0] sample
  );
    return {DAC_CMD_NIBBLE, sample, 2'b00};
  endfunction

endpackage

// File: rtl/awg_spi_tick.sv
// CLK_DIV phase counter: restarts on i_clear and ticks for one cycle every CLK_DIV cycles.
module awg_spi_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [7:0] LP_TC = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  assign o_tick = (r_cnt == LP_TC);

  always_ff @(posedge clk) begin
    if (rst || i_clear || o_tick) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/awg_dac_spi.sv
// SPI mode-0 serialiser for a 10-bit MCP4911-class DAC; one 16-bit frame per accepted sample.
// Define AWG_DAC_LDAC_EN to add a post-frame LDAC strobe; otherwise dac_ldac_n is tied low.
//
// state | meaning
// IDLE  | waiting for sample_valid, sample_ready high
// SETUP | CS low, first data bit presented before the first SCLK edge
// SHIFT | 16 bit periods, SCLK high phase then low phase
// CSHI  | CS high, minimum deselect time
// LDAC  | LDAC strobe low (only with AWG_DAC_LDAC_EN)
module awg_dac_spi
  import awg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DAC_SAMPLE_BITS-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       dac_cs_n,
  output logic                       dac_sclk,
  output logic                       dac_mosi,
  output logic                       dac_ldac_n,
  output logic                       busy,
  output logic                       frame_done
);

  dac_state_t r_state;
  dac_state_t w_state_nxt;

  logic [DAC_FRAME_BITS-1:0] r_shreg;
  logic [3:0]                r_bit;
  logic                      r_phase;   // 0: SCLK high phase, 1: SCLK low phase
  logic                      w_tick;
  logic                      w_clear;
  logic                      w_accept;
  logic                      w_in_frame;

  logic r_ready;
  logic r_cs_n;
  logic r_sclk;
  logic r_mosi;
  logic r_busy;
  logic r_done;

  assign w_accept   = sample_valid && r_ready;
  assign w_clear    = (w_state_nxt != r_state);
  assign w_in_frame = (r_state == SETUP) || (r_state == SHIFT);

  awg_spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = SETUP;
      SETUP: if (w_tick) w_state_nxt = SHIFT;
      SHIFT: if (w_tick && r_phase && (r_bit == 4'd15)) w_state_nxt = CSHI;
`ifdef AWG_DAC_LDAC_EN
      CSHI:  if (w_tick) w_state_nxt = LDAC;
`else
      CSHI:  if (w_tick) w_state_nxt = IDLE;
`endif
      LDAC:  if (w_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_bit   <= 4'd0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_shreg <= dac_frame(sample_in);
        r_bit   <= 4'd0;
        r_phase <= 1'b0;
      end else if ((r_state == SHIFT) && w_tick) begin
        if (!r_phase) begin
          r_phase <= 1'b1;
          // The last bit is held through the CS hold phase.
          if (r_bit != 4'd15) r_shreg <= {r_shreg[DAC_FRAME_BITS-2:0], 1'b0};
        end else begin
          r_phase <= 1'b0;
          r_bit   <= r_bit + 4'd1;
        end
      end
    end
  end

  // Pin outputs are registered copies of the current state, so the pins lag the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == IDLE);
      r_cs_n  <= !w_in_frame;
      r_sclk  <= (r_state == SHIFT) && !r_phase;
      r_mosi  <= w_in_frame ? r_shreg[DAC_FRAME_BITS-1] : 1'b0;
      r_busy  <= (r_state != IDLE);
      r_done  <= r_busy && (r_state == IDLE);
    end
  end

`ifdef AWG_DAC_LDAC_EN
  logic r_ldac_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ldac_n <= 1'b1;
    end else begin
      r_ldac_n <= (r_state != LDAC);
    end
  end

  assign dac_ldac_n = r_ldac_n;
`else
  assign dac_ldac_n = 1'b0;
`endif

  assign sample_ready = r_ready;
  assign dac_cs_n     = r_cs_n;
  assign dac_sclk     = r_sclk;
  assign dac_mosi     = r_mosi;
  assign busy         = r_busy;
  assign frame_done   = r_done;

endmodule

// File: tb/tb_awg_dac_spi.sv
// Bench for awg_dac_spi: one instance at CLK_DIV=2 (index 0) and one at CLK_DIV=1 (index 1).
module tb_awg_dac_spi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [2];
  logic [9:0] sin  [2];
  logic       vld  [2];
  logic       rdy  [2];
  logic       cs   [2];
  logic       sck  [2];
  logic       mosi [2];
  logic       ldac [2];
  logic       busy [2];
  logic       done [2];

  awg_dac_spi #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst[0]), .sample_in(sin[0]), .sample_valid(vld[0]),
    .sample_ready(rdy[0]), .dac_cs_n(cs[0]), .dac_sclk(sck[0]), .dac_mosi(mosi[0]),
    .dac_ldac_n(ldac[0]), .busy(busy[0]), .frame_done(done[0])
  );

  awg_dac_spi #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .sample_in(sin[1]), .sample_valid(vld[1]),
    .sample_ready(rdy[1]), .dac_cs_n(cs[1]), .dac_sclk(sck[1]), .dac_mosi(mosi[1]),
    .dac_ldac_n(ldac[1]), .busy(busy[1]), .frame_done(done[1])
  );

`ifdef AWG_DAC_LDAC_EN
  localparam bit HAS_LDAC = 1'b1;
  localparam logic RST_LDAC = 1'b1;
`else
  localparam bit HAS_LDAC = 1'b0;
  localparam logic RST_LDAC = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Per-frame measurements.
  logic [15:0] m_cap;
  int m_rise, m_busy, m_done, m_cs_lat, m_sck_lat, m_cs_rise;
  int m_bad_mosi, m_bad_gap, m_ldac_first, m_ldac_low, m_ldac_high, m_rdy_busy;
  bit m_timeout;

  task automatic run_frame(input int d, input logic [9:0] s, input bit inject);
    int   w, after, last_rise, cd;
    bit   seen_busy;
    logic prev_sck, prev_mosi, prev_cs;
    cd = (d == 0) ? 2 : 1;
    m_cap = '0; m_rise = 0; m_busy = 0; m_done = 0; m_cs_lat = -1; m_sck_lat = -1;
    m_cs_rise = -1; m_bad_mosi = 0; m_bad_gap = 0; m_ldac_first = -1; m_ldac_low = 0;
    m_ldac_high = 0; m_rdy_busy = 0; m_timeout = 0;
    w = 0;
    while (rdy[d] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (rdy[d] !== 1'b1) begin
      m_timeout = 1;
      return;
    end
    sin[d] = s;
    vld[d] = 1'b1;
    prev_sck = 1'b0; prev_mosi = mosi[d]; prev_cs = 1'b1;
    last_rise = -1; seen_busy = 0; after = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 0) begin
        vld[d] = 1'b0;
        sin[d] = '0;
      end
      if (inject && c == 20) begin
        sin[d] = 10'h155;
        vld[d] = 1'b1;
      end
      if (inject && c == 22) vld[d] = 1'b0;
      if (inject && c >= 20 && c <= 22 && rdy[d] !== 1'b0) m_rdy_busy++;
      if (busy[d]) begin
        m_busy++;
        seen_busy = 1;
      end
      if (done[d]) m_done++;
      if (!cs[d] && m_cs_lat < 0) m_cs_lat = c;
      if (cs[d] && !prev_cs && m_cs_lat >= 0 && m_cs_rise < 0) m_cs_rise = c;
      if (sck[d] && !prev_sck) begin
        if (m_sck_lat < 0) m_sck_lat = c;
        if (last_rise >= 0 && (c - last_rise) != 2 * cd) m_bad_gap++;
        last_rise = c;
        m_cap = {m_cap[14:0], mosi[d]};
        m_rise++;
      end
      // Data may only move at CS fall or on the first cycle of an SCLK low phase.
      if (!cs[d] && mosi[d] !== prev_mosi && c != m_cs_lat && !(prev_sck && !sck[d]))
        m_bad_mosi++;
      if (!ldac[d]) begin
        m_ldac_low++;
        if (m_ldac_first < 0) m_ldac_first = c;
      end else begin
        m_ldac_high++;
      end
      prev_sck = sck[d]; prev_mosi = mosi[d]; prev_cs = cs[d];
      if (seen_busy && !busy[d]) after++;
      if (after == 3) break;
    end
    if (after < 3) m_timeout = 1;
  endtask

  typedef struct {
    int          d;
    logic [9:0]  sample;
    logic [15:0] frame;
    int          busy_cyc;
    int          cd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rises, gap, t0, t1, cnt;
    logic prev_b;

    rst[0] = 1'b1; rst[1] = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    sin[0] = '0;   sin[1] = '0;

    vecs[0] = '{0, 10'h2AA, 16'h3AA8, HAS_LDAC ? 70 : 68, 2};
    vecs[1] = '{0, 10'h000, 16'h3000, HAS_LDAC ? 70 : 68, 2};
    vecs[2] = '{0, 10'h3FF, 16'h3FFC, HAS_LDAC ? 70 : 68, 2};
    vecs[3] = '{1, 10'h000, 16'h3000, HAS_LDAC ? 35 : 34, 1};
    vecs[4] = '{1, 10'h3FF, 16'h3FFC, HAS_LDAC ? 35 : 34, 1};
    vecs[5] = '{1, 10'h2AA, 16'h3AA8, HAS_LDAC ? 35 : 34, 1};
    vecs[6] = '{0, 10'h155, 16'h3554, HAS_LDAC ? 70 : 68, 2};

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_cs_n[%0d]", d), 32'(cs[d]), 32'd1);
      check($sformatf("rst_sclk[%0d]", d), 32'(sck[d]), 32'd0);
      check($sformatf("rst_mosi[%0d]", d), 32'(mosi[d]), 32'd0);
      check($sformatf("rst_busy[%0d]", d), 32'(busy[d]), 32'd0);
      check($sformatf("rst_done[%0d]", d), 32'(done[d]), 32'd0);
      check($sformatf("rst_ready[%0d]", d), 32'(rdy[d]), 32'd0);
      check($sformatf("rst_ldac[%0d]", d), 32'(ldac[d]), 32'(RST_LDAC));
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check("ready_after_rst[0]", 32'(rdy[0]), 32'd1);
    check("ready_after_rst[1]", 32'(rdy[1]), 32'd1);

    // Table of single frames.
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].d, vecs[i].sample, 1'b0);
      check($sformatf("v%0d_timeout", i), 32'(m_timeout), 32'd0);
      check($sformatf("v%0d_frame", i), 32'(m_cap), 32'(vecs[i].frame));
      check($sformatf("v%0d_rises", i), m_rise, 16);
      check($sformatf("v%0d_busy", i), m_busy, vecs[i].busy_cyc);
      check($sformatf("v%0d_done", i), m_done, 1);
      check($sformatf("v%0d_cs_lat", i), m_cs_lat, 1);
      check($sformatf("v%0d_sclk_lat", i), m_sck_lat, 1 + vecs[i].cd);
      check($sformatf("v%0d_cs_rise", i), m_cs_rise, 1 + 33 * vecs[i].cd);
      check($sformatf("v%0d_sclk_gap", i), m_bad_gap, 0);
      check($sformatf("v%0d_mosi_stable", i), m_bad_mosi, 0);
      if (HAS_LDAC) begin
        check($sformatf("v%0d_ldac_start", i), m_ldac_first, m_cs_rise + vecs[i].cd);
        check($sformatf("v%0d_ldac_len", i), m_ldac_low, vecs[i].cd);
      end else begin
        check($sformatf("v%0d_ldac_tied", i), m_ldac_high, 0);
      end
    end

    // Valid pulsed mid-frame must be ignored.
    run_frame(0, 10'h2AA, 1'b1);
    check("busy_valid_timeout", 32'(m_timeout), 32'd0);
    check("busy_valid_frame", 32'(m_cap), 32'h3AA8);
    check("busy_valid_ready", m_rdy_busy, 0);
    check("busy_valid_done", m_done, 1);
    repeat (HAS_LDAC ? 80 : 75) @(negedge clk);
    check("busy_valid_no_second", 32'(busy[0]), 32'd0);

    // Reset after 5 SCLK rising edges aborts the frame.
    sin[0] = 10'h2AA;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    rises = 0; prev_b = 1'b0; cnt = 0;
    for (int c = 0; c < 200 && rises < 5; c++) begin
      @(negedge clk);
      if (sck[0] && !prev_b) rises++;
      prev_b = sck[0];
    end
    check("abort_reached_5_edges", rises, 5);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_cs_n", 32'(cs[0]), 32'd1);
    check("abort_sclk", 32'(sck[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    rst[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done[0]) cnt++;
    end
    check("abort_no_done", cnt, 0);
    run_frame(0, 10'h001, 1'b0);
    check("post_abort_frame", 32'(m_cap), 32'h3004);
    check("post_abort_done", m_done, 1);

    // Back-to-back with valid held high on the CLK_DIV=1 instance.
    sin[1] = 10'h3FF;
    vld[1] = 1'b1;
    t0 = -1; t1 = -1; prev_b = busy[1];
    for (int c = 0; c < 200 && t1 < 0; c++) begin
      @(negedge clk);
      if (busy[1] && !prev_b) begin
        if (t0 < 0) t0 = c;
        else t1 = c;
      end
      prev_b = busy[1];
    end
    vld[1] = 1'b0;
    gap = (t1 < 0 || t0 < 0) ? -1 : (t1 - t0);
    check("b2b_period", gap, HAS_LDAC ? 36 : 35);
    repeat (50) @(negedge clk);
    check("b2b_idle", 32'(busy[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
